// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI slave register bank: FSM state encoding,
// command-word field positions and sclk edge selection.
package spi_regbank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } spi_state_e;

  // Read/not-write flag sits in the MSB of the command word.
  function automatic int cmd_rw_bit(input int data_w);
    return data_w - 1;
  endfunction

  // 1 when data is sampled on the falling sclk edge (CPOL^CPHA == 1).
  function automatic logic edge_sel(input int cpol, input int cpha);
    return logic'((cpol % 2) != (cpha % 2));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with single-cycle rise/fall
// pulses derived from the synchronised level.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= {SYNC_STAGES{RST_VAL}};
      prev_p <= RST_VAL;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign level = sync_p[SYNC_STAGES-1];
  assign rise  = level & ~prev_p;
  assign fall  = ~level & prev_p;

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave (any CPOL/CPHA, DATA_W-bit words) with a command/address phase and an
// auto-incrementing register bank. Define SPI_READBACK_EN to enable register reads.
module spi_slave_regbank
  import spi_regbank_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sclk,
  input  logic                       mosi,
  input  logic                       ce0,
  output logic                       miso,
  output logic                       ssig,
  output logic [DATA_W-1:0]          rx_word,
  output logic                       rx_valid,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic [NUM_REGS*DATA_W-1:0] reg_out
);

  localparam int   ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int   CNT_W       = $clog2(DATA_W);
  localparam logic SAMPLE_FALL = edge_sel(CPOL, CPHA);
  localparam logic CPHA_HOLD   = logic'(CPHA != 0);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic ce_lvl, ce_rise_unused, ce_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ce (
    .clk(clk), .rst_n(rst_n), .din(ce0),
    .level(ce_lvl), .rise(ce_rise_unused), .fall(ce_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [DATA_W-2:0]  rx_sh_q;
  logic [DATA_W-1:0]  rx_next;
  logic [DATA_W-1:0]  tx_sh_q;
  logic               hold_q;
  logic [ADDR_W-1:0]  addr_q, addr_d, cmd_addr;
  logic [DATA_W-1:0]  reg_q [NUM_REGS];

  logic               frame_on, sample_pulse, shift_pulse, word_done, rd_cmd;
  logic               tx_load, tx_hold_d, wr_en;
  logic [DATA_W-1:0]  tx_load_val, frame_start_val;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
  endfunction

  // Out-of-range start addresses (non power-of-two bank) fold back into the bank.
  function automatic logic [ADDR_W-1:0] addr_fold(input logic [ADDR_W-1:0] a);
    if ({1'b0, a} >= (ADDR_W+1)'(NUM_REGS)) return a - ADDR_W'(NUM_REGS);
    return a;
  endfunction

  // sclk edges only count inside an active frame; a ce0 rise kills them immediately.
  assign frame_on     = (state_q != IDLE) && !ce_lvl;
  assign sample_pulse = frame_on && (SAMPLE_FALL ? sclk_fall : sclk_rise);
  assign shift_pulse  = frame_on && (SAMPLE_FALL ? sclk_rise : sclk_fall);
  assign word_done    = sample_pulse && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign rx_next      = {rx_sh_q, mosi_lvl};
  assign cmd_addr     = addr_fold(rx_next[ADDR_W-1:0]);

`ifdef SPI_READBACK_EN
  localparam int RW_BIT = cmd_rw_bit(DATA_W);
  assign rd_cmd          = rx_next[RW_BIT];
  assign frame_start_val = DATA_W'(NUM_REGS);
`else
  assign rd_cmd          = 1'b0;
  assign frame_start_val = rx_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tx_load     = 1'b0;
    tx_load_val = rx_next;
    tx_hold_d   = 1'b1;
    wr_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ce_fall) begin
          state_d     = CMD;
          tx_load     = 1'b1;
          tx_load_val = frame_start_val;
          tx_hold_d   = CPHA_HOLD;
        end
      end
      CMD: begin
        if (word_done) begin
          tx_load = 1'b1;
          if (rd_cmd) begin
            state_d     = READ;
            tx_load_val = reg_q[cmd_addr];
            addr_d      = addr_inc(cmd_addr);
          end else begin
            state_d = WRITE;
            addr_d  = cmd_addr;
          end
        end
      end
      WRITE: begin
        if (word_done) begin
          tx_load = 1'b1;
          wr_en   = 1'b1;
          addr_d  = addr_inc(addr_q);
        end
      end
      READ: begin
        if (word_done) begin
          tx_load     = 1'b1;
          tx_load_val = reg_q[addr_q];
          addr_d      = addr_inc(addr_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (ce_lvl) state_d = IDLE;
  end

  // Receive path: bit counter, shifter, completed-word register and register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      rx_word   <= '0;
      rx_valid  <= 1'b0;
      wr_strobe <= '0;
      addr_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
    end else begin
      rx_valid  <= word_done;
      wr_strobe <= '0;
      addr_q    <= addr_d;
      if (!frame_on) begin
        bit_cnt_q <= '0;
        rx_sh_q   <= '0;
      end else if (sample_pulse) begin
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
        rx_sh_q   <= rx_next[DATA_W-2:0];
      end
      if (word_done) rx_word <= rx_next;
      if (wr_en) begin
        reg_q[addr_q]     <= rx_next;
        wr_strobe[addr_q] <= 1'b1;
      end
    end
  end

  // Transmit path: after every load the next shift edge only presents the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q <= '0;
      hold_q  <= 1'b0;
    end else if (tx_load) begin
      tx_sh_q <= tx_load_val;
      hold_q  <= tx_hold_d;
    end else if (shift_pulse) begin
      if (hold_q) hold_q  <= 1'b0;
      else        tx_sh_q <= {tx_sh_q[DATA_W-2:0], 1'b0};
    end
  end

  assign miso = (state_q != IDLE) & tx_sh_q[DATA_W-1];
  assign ssig = ~ce_lvl;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// Bench for spi_slave_regbank: four instances (SPI modes 0..3) driven by one master
// model; a scoreboard checks rx_valid/rx_word and wr_strobe/register events of mode 0.
module tb_spi_slave_regbank;

  localparam int Q = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mosi;
  logic       ce0;
  logic [3:0] sclk_v;
  logic [3:0] miso_v, ssig_v, rx_valid_v;
  logic [7:0]  rx_word_v [4];
  logic [3:0]  wr_v      [4];
  logic [31:0] reg_out_v [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_regbank #(
      .DATA_W(8), .NUM_REGS(4), .CPOL(g / 2), .CPHA(g % 2), .SYNC_STAGES(2)
    ) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk_v[g]), .mosi(mosi), .ce0(ce0),
      .miso(miso_v[g]), .ssig(ssig_v[g]), .rx_word(rx_word_v[g]),
      .rx_valid(rx_valid_v[g]), .wr_strobe(wr_v[g]), .reg_out(reg_out_v[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] fw [4];
  logic [7:0] fm [4];
  logic [7:0] exp_rx_q [$];
  logic [9:0] exp_wr_q [$];
  logic [7:0] mon_rx;
  logic [9:0] mon_wr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  task automatic push_rx(input logic [7:0] w);
    exp_rx_q.push_back(w);
  endtask

  task automatic push_wr(input logic [1:0] idx, input logic [7:0] d);
    exp_wr_q.push_back({idx, d});
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] req);
    for (int m = 0; m < 4; m++) chk($sformatf("%s reg_out mode%0d", tag, m), reg_out_v[m], req);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " miso"},     32'(miso_v[0]),     32'd0);
    chk({tag, " ssig"},     32'(ssig_v[0]),     32'd0);
    chk({tag, " rx_valid"}, 32'(rx_valid_v[0]), 32'd0);
    chk({tag, " wr_strobe"}, 32'(wr_v[0]),      32'd0);
    chk({tag, " rx_word"},  32'(rx_word_v[0]),  32'd0);
    chk_regs(tag, 32'd0);
  endtask

  // Command-word miso: capability byte with readback, otherwise the previous word echoed.
  function automatic logic [7:0] w0(input logic [7:0] echo);
`ifdef SPI_READBACK_EN
    return 8'h04 | (echo & 8'h00);
`else
    return echo;
`endif
  endfunction

  // Scoreboard monitor for the mode-0 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rx_valid_v[0]) begin
        if (exp_rx_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rx_valid: got unexpected word 0x%0h, required no pulse", rx_word_v[0]);
        end else begin
          mon_rx = exp_rx_q.pop_front();
          chk("rx_word", 32'(rx_word_v[0]), 32'(mon_rx));
        end
      end
      if (wr_v[0] != 4'b0) begin
        if (exp_wr_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL wr_strobe: got unexpected 0x%0h, required none", wr_v[0]);
        end else begin
          mon_wr = exp_wr_q.pop_front();
          chk("wr_strobe", 32'(wr_v[0]), 32'(4'b0001 << mon_wr[9:8]));
          chk("reg written", 32'(reg_out_v[0][32'(mon_wr[9:8])*8 +: 8]), 32'(mon_wr[7:0]));
        end
      end
    end
  end

  // Master model. Per bit: q0 leading edge (CPHA=1), q1 mosi update,
  // q2 sample edge for every mode (miso captured here), q3 trailing edge (CPHA=0).
  task automatic run_frame(input int nw, input int last_bits, input int rst_word, input int rst_bit);
    logic [7:0] got [4];
    int nb;
    ce0 = 1'b0;
    #(2*Q);
    for (int w = 0; w < nw; w++) begin
      nb = (w == nw - 1) ? last_bits : 8;
      for (int b = 0; b < nb; b++) begin
        if (w == rst_word && b == rst_bit) begin
          rst_n = 1'b0;
          #1;
          check_zero("mid-frame reset");
          ce0  = 1'b1;
          mosi = 1'b0;
          return;
        end
        for (int m = 0; m < 4; m++) if (m % 2 == 1) sclk_v[m] = ~sclk_v[m];
        #Q;
        mosi = fw[w][7-b];
        #Q;
        for (int m = 0; m < 4; m++) begin
          got[m][7-b] = miso_v[m];
          sclk_v[m]   = ~sclk_v[m];
        end
        if (w == 0 && b == 0) chk("ssig in frame", 32'(ssig_v[0]), 32'd1);
        #Q;
        for (int m = 0; m < 4; m++) if (m % 2 == 0) sclk_v[m] = ~sclk_v[m];
        #Q;
      end
      if (nb == 8)
        for (int m = 0; m < 4; m++)
          chk($sformatf("miso mode%0d word%0d", m, w), 32'(got[m]), 32'(fm[w]));
    end
    #Q;
    ce0  = 1'b1;
    mosi = 1'b0;
    #(4*Q);
  endtask

  initial begin
    rst_n  = 1'b0;
    ce0    = 1'b1;
    mosi   = 1'b0;
    sclk_v = 4'b1100;
    #(3*Q);
    check_zero("reset");
    rst_n = 1'b1;
    #(2*Q);

    // Basic write burst, all four modes in parallel.
    push_rx(8'h01); push_rx(8'hA5); push_rx(8'h3C);
    push_wr(2'd1, 8'hA5); push_wr(2'd2, 8'h3C);
    fw = '{8'h01, 8'hA5, 8'h3C, 8'h00};
    fm = '{w0(8'h00), 8'h01, 8'hA5, 8'h00};
    run_frame(3, 8, -1, 0);
    chk_regs("burst", 32'h003C_A500);
    for (int m = 1; m < 4; m++) chk($sformatf("rx_word mode%0d", m), 32'(rx_word_v[m]), 32'h3C);

    // Address wrap from reg3 to reg0.
    push_rx(8'h03); push_rx(8'h11); push_rx(8'h22);
    push_wr(2'd3, 8'h11); push_wr(2'd0, 8'h22);
    fw = '{8'h03, 8'h11, 8'h22, 8'h00};
    fm = '{w0(8'h3C), 8'h03, 8'h11, 8'h00};
    run_frame(3, 8, -1, 0);
    chk_regs("wrap", 32'h113C_A522);

    // Abort after 5 data bits, then a normal frame.
    push_rx(8'h00);
    fw = '{8'h00, 8'hFF, 8'h00, 8'h00};
    fm = '{w0(8'h22), 8'h00, 8'h00, 8'h00};
    run_frame(2, 5, -1, 0);
    chk("abort ssig", 32'(ssig_v[0]), 32'd0);
    chk("abort miso", 32'(miso_v[0]), 32'd0);
    chk_regs("abort", 32'h113C_A522);
    push_rx(8'h00); push_rx(8'h77);
    push_wr(2'd0, 8'h77);
    fw = '{8'h00, 8'h77, 8'h00, 8'h00};
    fm = '{w0(8'h00), 8'h00, 8'h00, 8'h00};
    run_frame(2, 8, -1, 0);
    chk_regs("after abort", 32'h113C_A577);

`ifdef SPI_READBACK_EN
    push_rx(8'h02); push_rx(8'h5A); push_rx(8'hC3);
    push_wr(2'd2, 8'h5A); push_wr(2'd3, 8'hC3);
    fw = '{8'h02, 8'h5A, 8'hC3, 8'h00};
    fm = '{8'h04, 8'h02, 8'h5A, 8'h00};
    run_frame(3, 8, -1, 0);
    chk_regs("preload", 32'hC35A_A577);
    push_rx(8'h82); push_rx(8'h00); push_rx(8'h00);
    fw = '{8'h82, 8'h00, 8'h00, 8'h00};
    fm = '{8'h04, 8'h5A, 8'hC3, 8'h00};
    run_frame(3, 8, -1, 0);
    chk_regs("readback", 32'hC35A_A577);
    fm = '{8'h04, 8'h00, 8'h00, 8'h00};
`else
    // R/nW bit set but ignored: still a write to reg2.
    push_rx(8'h82); push_rx(8'h66);
    push_wr(2'd2, 8'h66);
    fw = '{8'h82, 8'h66, 8'h00, 8'h00};
    fm = '{8'h77, 8'h82, 8'h00, 8'h00};
    run_frame(2, 8, -1, 0);
    chk_regs("rw ignored", 32'h1166_A577);
    fm = '{8'h66, 8'h00, 8'h00, 8'h00};
`endif

    // Reset asserted during data bit 4, then a full frame.
    push_rx(8'h01);
    fw = '{8'h01, 8'hFF, 8'h00, 8'h00};
    run_frame(2, 8, 1, 4);
    #(2*Q);
    rst_n = 1'b1;
    #(2*Q);
    push_rx(8'h01); push_rx(8'hA5); push_rx(8'h3C);
    push_wr(2'd1, 8'hA5); push_wr(2'd2, 8'h3C);
    fw = '{8'h01, 8'hA5, 8'h3C, 8'h00};
    fm = '{w0(8'h00), 8'h01, 8'hA5, 8'h00};
    run_frame(3, 8, -1, 0);
    chk_regs("after reset", 32'h003C_A500);

    #(4*Q);
    chk("rx events outstanding", 32'(exp_rx_q.size()), 32'd0);
    chk("wr events outstanding", 32'(exp_wr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
